// File: rtl/clkseq_pkg.sv
// Shared types and terminal-count helpers for the clock-group reset sequencer.
package clkseq_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_GATE   = 3'd2,
        ST_RESET  = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    localparam int CLKSEQ_CNT_W = 8;

    // A phase lasting N cycles ends when the counter (started at 0) reads N-1.
    function automatic int unsigned last_count(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/clkseq_phase_counter.sv
// Phase counter: clears on state change, counts while enabled, flags the terminal value.
// Holds at the terminal value instead of wrapping, so an unbounded wait never aliases.
module clkseq_phase_counter
    import clkseq_pkg::*;
#(
    parameter int W = CLKSEQ_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         at_term
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !at_term) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Drain -> gate -> reset -> settle -> run sequencer for one clock-group member; request accepted only in RUN.
// Optional drain timeout under CLKSEQ_DRAIN_TIMEOUT_EN; otherwise DRAIN waits for the member's ack forever.
module clock_group_reset_sequencer
    import clkseq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = CLKSEQ_CNT_W,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic io_req_valid,
    output logic io_req_ready,
    output logic io_quiesce_req,
    input  logic io_quiesce_ack,
    output logic io_member_clock_en,
    output logic io_member_reset,
    output logic io_busy,
    output logic io_done,
    output logic io_timeout
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(last_count(RST_CYCLES));
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(last_count(SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(last_count(DRAIN_TIMEOUT));

    state_t           state;
    state_t           state_nxt;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             at_term;
    logic [CNT_W-1:0] term;
    logic             done_q;
`ifdef CLKSEQ_DRAIN_TIMEOUT_EN
    logic             set_timeout;
    logic             timeout_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_GATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        term = '0;
        case (state)
            ST_DRAIN:  term = DRAIN_LAST;
            ST_RESET:  term = RST_LAST;
            ST_SETTLE: term = SETTLE_LAST;
            default:   term = '0;
        endcase
    end

    always_comb begin
        state_nxt          = state;
        cnt_inc            = 1'b0;
        io_member_clock_en = 1'b0;
        io_member_reset    = 1'b1;
        io_quiesce_req     = 1'b0;
        io_req_ready       = 1'b0;
`ifdef CLKSEQ_DRAIN_TIMEOUT_EN
        set_timeout        = 1'b0;
`endif
        case (state)
            ST_RUN: begin
                io_member_clock_en = 1'b1;
                io_member_reset    = 1'b0;
                io_req_ready       = 1'b1;
                if (io_req_valid) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                io_member_clock_en = 1'b1;
                io_member_reset    = 1'b0;
                io_quiesce_req     = 1'b1;
                cnt_inc            = 1'b1;
                if (io_quiesce_ack) begin
                    state_nxt = ST_GATE;
`ifdef CLKSEQ_DRAIN_TIMEOUT_EN
                end else if (at_term) begin
                    state_nxt   = ST_GATE;
                    set_timeout = 1'b1;
`endif
                end
            end
            ST_GATE: begin
                state_nxt = ST_RESET;
            end
            ST_RESET: begin
                // Reset is held with the clock running so the member sees real edges.
                io_member_clock_en = 1'b1;
                cnt_inc            = 1'b1;
                if (at_term) begin
                    state_nxt = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                io_member_clock_en = 1'b1;
                io_member_reset    = 1'b0;
                cnt_inc            = 1'b1;
                if (at_term) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_GATE;
            end
        endcase
    end

    assign cnt_clr = (state_nxt != state);
    assign io_busy = (state != ST_RUN);

    clkseq_phase_counter #(
        .W(CNT_W)
    ) u_phase_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clr),
        .inc    (cnt_inc),
        .term   (term),
        .at_term(at_term)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_nxt == ST_RUN) && (state != ST_RUN);
        end
    end

    assign io_done = done_q;

`ifdef CLKSEQ_DRAIN_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (state == ST_RUN && io_req_valid) begin
            timeout_q <= 1'b0;
        end else if (set_timeout) begin
            timeout_q <= 1'b1;
        end
    end

    assign io_timeout = timeout_q;
`else
    assign io_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Randomized scoreboard bench: per-cycle expected outputs and done-cycle numbers are queued by the stimulus and checked by a monitor.
module tb_clock_group_reset_sequencer;

    localparam int RST = 16;
    localparam int SET = 4;
    localparam int CW  = 8;
    localparam int DTO = 255;

    localparam int P_RUN    = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_GATE   = 2;
    localparam int P_RESET  = 3;
    localparam int P_SETTLE = 4;

    typedef struct packed {
        logic clock_en;
        logic member_reset;
        logic quiesce_req;
        logic req_ready;
        logic busy;
        logic done;
        logic timeout;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    logic io_req_valid;
    logic io_req_ready;
    logic io_quiesce_req;
    logic io_quiesce_ack;
    logic io_member_clock_en;
    logic io_member_reset;
    logic io_busy;
    logic io_done;
    logic io_timeout;

    clock_group_reset_sequencer #(
        .RST_CYCLES   (RST),
        .SETTLE_CYCLES(SET),
        .CNT_W        (CW),
        .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_req_valid      (io_req_valid),
        .io_req_ready      (io_req_ready),
        .io_quiesce_req    (io_quiesce_req),
        .io_quiesce_ack    (io_quiesce_ack),
        .io_member_clock_en(io_member_clock_en),
        .io_member_reset   (io_member_reset),
        .io_busy           (io_busy),
        .io_done           (io_done),
        .io_timeout        (io_timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    vec_t sb[$];
    int   done_q[$];
    int   tests = 0;
    int   fails = 0;
    logic model_to = 1'b0;

    // Expected outputs for a phase, straight from the per-state output table.
    function automatic vec_t pv(input int ph, input logic dn);
        vec_t v;
        v = '0;
        v.done    = dn;
        v.timeout = model_to;
        v.busy    = (ph != P_RUN);
        case (ph)
            P_RUN:    begin v.clock_en = 1'b1; v.req_ready = 1'b1; end
            P_DRAIN:  begin v.clock_en = 1'b1; v.quiesce_req = 1'b1; end
            P_GATE:   begin v.member_reset = 1'b1; end
            P_RESET:  begin v.clock_en = 1'b1; v.member_reset = 1'b1; end
            P_SETTLE: begin v.clock_en = 1'b1; end
            default:  v = '0;
        endcase
        return v;
    endfunction

    always @(negedge clock) begin : monitor
        vec_t e;
        vec_t a;
        int   dc;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {io_member_clock_en, io_member_reset, io_quiesce_req, io_req_ready,
                 io_busy, io_done, io_timeout};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL outputs cycle=%0d got=%b want=%b (clk_en,mrst,qreq,rdy,busy,done,to)",
                         cyc, a, e);
            end
        end
        if (io_done === 1'b1) begin
            tests++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL done_pulse cycle=%0d got=1 want=no pulse", cyc);
            end else begin
                dc = done_q.pop_front();
                if (dc != cyc) begin
                    fails++;
                    $display("FAIL done_cycle got=%0d want=%0d", cyc, dc);
                end
            end
        end
    end

    task automatic cycle(input vec_t e);
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycle(input logic dn, input logic req);
        io_req_valid = req;
        if (dn) done_q.push_back(cyc);
        cycle(pv(P_RUN, dn));
    endtask

    // GATE, RESET, SETTLE; optionally pulls reset after 'abort' RESET cycles.
    task automatic phases_from_gate(input int abort, output bit aborted);
        aborted = 1'b0;
        io_req_valid   = ($urandom_range(0, 1) == 1);
        io_quiesce_ack = ($urandom_range(0, 1) == 1);
        cycle(pv(P_GATE, 1'b0));
        for (int k = 0; k < RST && !aborted; k++) begin
            io_req_valid   = ($urandom_range(0, 1) == 1);
            io_quiesce_ack = ($urandom_range(0, 1) == 1);
            if (k == abort) begin
                reset    = 1'b1;
                model_to = 1'b0;
                cycle(pv(P_GATE, 1'b0));
                cycle(pv(P_GATE, 1'b0));
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                cycle(pv(P_RESET, 1'b0));
            end
        end
        if (!aborted) begin
            for (int k = 0; k < SET; k++) begin
                io_req_valid = ($urandom_range(0, 1) == 1);
                cycle(pv(P_SETTLE, 1'b0));
            end
        end
        io_req_valid = 1'b0;
    endtask

    // Ack arrives d cycles after DRAIN entry, so DRAIN lasts d+1 cycles unless it times out.
    task automatic request(input int d, input int abort);
        int len;
        bit ab;
        model_to = 1'b0;
        len = d + 1;
`ifdef CLKSEQ_DRAIN_TIMEOUT_EN
        if (d >= DTO) len = DTO;
`endif
        for (int k = 0; k < len; k++) begin
            io_quiesce_ack = (k == d);
            io_req_valid   = ($urandom_range(0, 1) == 1);
            cycle(pv(P_DRAIN, 1'b0));
        end
`ifdef CLKSEQ_DRAIN_TIMEOUT_EN
        if (d >= DTO) model_to = 1'b1;
`endif
        phases_from_gate(abort, ab);
        if (ab) phases_from_gate(-1, ab);
    endtask

    initial begin : stimulus
        bit dn;
        bit ab;
        int d;
        int ab_at;
        int idle;
        reset          = 1'b1;
        io_req_valid   = 1'b0;
        io_quiesce_ack = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            io_req_valid = ($urandom_range(0, 1) == 1);
            cycle(pv(P_GATE, 1'b0));
        end
        reset        = 1'b0;
        io_req_valid = 1'b0;
        phases_from_gate(-1, ab);
        dn = 1'b1;
        for (int s = 0; s < 40; s++) begin
            ab_at = -1;
            idle  = int'($urandom_range(0, 3));
            case (s)
                0:       begin d = 0;   idle = 1; io_quiesce_ack = 1'b1; end
                1:       begin d = 10;  idle = 2; end
                2:       begin d = 2;   ab_at = 5; end
                3:       begin d = 300; end
                4:       begin d = 1;   idle = 0; end
                default: d = int'($urandom_range(0, 12));
            endcase
            for (int i = 0; i < idle; i++) begin
                run_cycle(dn, 1'b0);
                dn = 1'b0;
            end
            run_cycle(dn, 1'b1);
            dn = 1'b0;
            request(d, ab_at);
            dn = 1'b1;
        end
        run_cycle(dn, 1'b0);
        run_cycle(1'b0, 1'b0);
        tests++;
        if (sb.size() != 0 || done_q.size() != 0) begin
            fails++;
            $display("FAIL queues_empty got sb=%0d done_q=%0d want 0 0", sb.size(), done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_group_reset_sequencer.md
Name: clock_group_reset_sequencer

Overview:
- Sequences clock enable and reset for one clock-group member domain (e.g. subsystem_l2_0).
- Sits between the clock-group aggregator and the member's clock gate / reset input.
- On power-up and on each software request, it runs: drain the member, gate the clock, hold reset with the clock running, settle, then resume.
- Handshakes with a requester and with the member's quiesce logic.

Parameters:
- RST_CYCLES, 16, cycles member reset is held with clock running; must be ≥1 and < 2^CNT_W.
- SETTLE_CYCLES, 4, cycles after reset release before returning to RUN; 0 skips SETTLE.
- CNT_W, 8, width of the shared phase counter.
- DRAIN_TIMEOUT, 255, maximum DRAIN cycles; used only with the optional feature.

Ports:
- clock  input  1  block clock.
- reset  input  1  asynchronous, active-high reset.
- io_req_valid  input  1  request a full reset cycle of the member.
- io_req_ready  output  1  request accepted when valid&ready.
- io_quiesce_req  output  1  asks the member to drain outstanding traffic.
- io_quiesce_ack  input  1  member reports it is drained.
- io_member_clock_en  output  1  enable for the member clock gate.
- io_member_reset  output  1  reset to the member, active high.
- io_busy  output  1  high in every state except RUN.
- io_done  output  1  one-cycle pulse on entering RUN.
- io_timeout  output  1  sticky drain-timeout flag; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clock and reset.
- State register and counter are async-reset; all outputs are Moore decodes of the registered state, except io_done, which is a registered pulse.
- Values while reset is asserted: state=GATE, counter=0, io_member_clock_en=0, io_member_reset=1, io_quiesce_req=0, io_req_ready=0, io_busy=1, io_done=0, io_timeout=0.
- Outputs by state (clock_en, member_reset, quiesce_req, req_ready):
  - RUN: 1, 0, 0, 1.
  - DRAIN: 1, 0, 1, 0.
  - GATE: 0, 1, 0, 0.
  - RESET: 1, 1, 0, 0.
  - SETTLE: 1, 0, 0, 0.
- Transitions:
  - RUN → DRAIN on req_valid&req_ready.
  - DRAIN → GATE in the cycle after quiesce_ack is sampled high. Ack is sampled only in DRAIN, so an ack already high on DRAIN's first cycle gives exactly one DRAIN cycle.
  - GATE lasts exactly 1 cycle → RESET; the counter is cleared on entry.
  - RESET lasts exactly RST_CYCLES cycles → SETTLE, or → RUN directly if SETTLE_CYCLES=0.
  - SETTLE lasts exactly SETTLE_CYCLES cycles → RUN.
- io_done=1 in the first RUN cycle after SETTLE/RESET, including after power-on.
- Power-on timeline (RST_CYCLES=16, SETTLE_CYCLES=4), cycle 0 = first edge after reset deasserts: GATE 0, RESET 1..16, SETTLE 17..20, RUN 21 with done=1.
- Request timeline, accept at cycle t with ack already high: DRAIN t+1, GATE t+2, RESET t+3..t+18, SETTLE t+19..t+22, RUN t+23 with done=1.
- io_req_valid outside RUN is ignored and not queued; a request held high through the done cycle is accepted in that cycle (back-to-back requests).
- Counter is CNT_W bits, increments in RESET/SETTLE/DRAIN, clears on every state change, and never wraps because terminal counts are below 2^CNT_W.
- Reset asserted mid-sequence: outputs go to reset values immediately; the sequence restarts from GATE after deassertion.
- Member clock is never gated while member_reset=0, except in GATE, which is always preceded by DRAIN or reset.

Optional Feature:
- Macro: CLKSEQ_DRAIN_TIMEOUT_EN.
- With the macro: if quiesce_ack is not seen within DRAIN_TIMEOUT DRAIN cycles, the block moves to GATE anyway and sets io_timeout. io_timeout stays high until the next accepted request or reset.
- Without the macro: DRAIN waits indefinitely and io_timeout is constant 0.

Decomposition:
- Package clkseq_pkg holds:
  - the state enum (RUN, DRAIN, GATE, RESET, SETTLE), binary encoded;
  - the CNT_W default;
  - the localparam terminal-count helpers.
- One sub-module, clkseq_phase_counter: a clear/increment counter with an equality-to-terminal output, instantiated once.

Test Plan:
- Power-on, RST=16, SETTLE=4 → clock_en low for cycle 0 only; member_reset high in cycles 0..16; done pulses in cycle 21; busy low from cycle 21.
- Request at t with ack tied high → quiesce_req high for 1 cycle, done at t+23, req_ready low during t+1..t+22.
- Ack delayed 10 cycles after DRAIN entry → DRAIN lasts 11 cycles; total latency 33.
- req_valid pulsed during RESET → ignored, no second sequence; req_valid held through done → second DRAIN starts the next cycle.
- Reset asserted in RESET phase count 5 → outputs return to reset values the same cycle; after release, the full 21-cycle power-on timeline repeats.
- With CLKSEQ_DRAIN_TIMEOUT_EN, DRAIN_TIMEOUT=255, ack never high → GATE after 255 DRAIN cycles with io_timeout=1; io_timeout clears on the next accepted request.
